// File: rtl/led_pkg.sv
// Shared definitions for the LED scan controller: digit counts, FSM states,
// active-low seven-segment patterns and the double-dabble adjust step.
package led_pkg;

  localparam int BIN_W        = 32;
  localparam int BCD_DIGITS   = 10;
  localparam int SHOWN_DIGITS = 8;
  localparam int BCD_W        = 4 * BCD_DIGITS;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Value-offer handshake between the CPU LED port and the scan controller.
interface led_scan_ctrl_if;
  import led_pkg::*;

  logic             in_valid;
  logic [BIN_W-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/led_scan_ctrl_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decode
  import led_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg_n
);

  // Blank wins; non-decimal codes also come out dark.
  always_comb begin
    seg_n = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Binary-to-BCD converter feeding an 8-digit multiplexed seven-segment display.
// The converter FSM and the refresh scanner run independently; they share only
// the display register, which changes atomically on COMMIT.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_scan_ctrl_if.slave        bus,
  output logic                  busy,
  output logic                  ovf,
  output logic [7:0]            an_n,
  output logic [7:0]            seg_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  state_t                  state_q, state_d;
  logic [BIN_W-1:0]        bin_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [4:0]              cnt_q;
  logic [BIN_W-1:0]        disp_q;
  logic                    accept;
  logic                    last_shift;

  logic [PW-1:0]           presc_q;
  logic                    tick;
  logic [2:0]              idx_q;
  logic [2:0]              idx_nx;
  logic [3:0]              digit_sel;
  logic [SHOWN_DIGITS-1:0] hi_zero;
  logic                    blank_sel;
  logic [7:0]              seg_nx;

  assign accept       = bus.in_valid && (state_q == IDLE);
  assign last_shift   = (cnt_q == 5'd31);
  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q == CONV) || (state_q == COMMIT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one accept, 32 shift cycles, one commit cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CONV;
      CONV:    if (last_shift)   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift counter: counts the 32 double-dabble iterations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == CONV) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // Conversion datapath: adjust every BCD nibble, then shift {bcd,bin} left.
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_q <= bus.in_data;
      bcd_q <= '0;
    end else if (state_q == CONV) begin
      {bcd_q, bin_q} <= {bcd_add3(bcd_q), bin_q} << 1;
    end
  end

  // Display register and overflow flag, written only on COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      ovf    <= 1'b0;
    end else if (state_q == COMMIT) begin
      disp_q <= bcd_q[BIN_W-1:0];
      ovf    <= |bcd_q[BCD_W-1:BIN_W];
    end
  end

  assign tick   = (presc_q == PRESC_LAST);
  assign idx_nx = idx_q + 3'd1;

  // Leading-zero map: hi_zero[i] is set when digits i..7 are all zero.
  always_comb begin
    hi_zero = '0;
    for (int i = 0; i < SHOWN_DIGITS; i++) begin
      hi_zero[i] = ((disp_q >> (4 * i)) == '0);
    end
  end

  assign digit_sel = disp_q[{idx_nx, 2'b00} +: 4];
  assign blank_sel = BLANK_LZ && (idx_nx != 3'd0) && hi_zero[idx_nx];

  seg7_decode u_seg7_decode (
    .digit (digit_sel),
    .blank (blank_sel),
    .seg_n (seg_nx)
  );

  // Refresh scanner: prescaler, digit index and the registered pin drive.
  // Anode and segments load on the same tick so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_n    <= 8'hFE;
      seg_n   <= SEG_0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        idx_q <= idx_nx;
        an_n  <= ~(8'd1 << idx_nx);
        seg_n <= seg_nx;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized scoreboard bench for led_scan_ctrl with a decimal reference model.
module tb_led_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam bit BLANK_LZ = 1'b1;
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       ovf;
  logic [7:0] an_n;
  logic [7:0] seg_n;

  led_scan_ctrl_if bus();

  led_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy),
    .ovf   (ovf),
    .an_n  (an_n),
    .seg_n (seg_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_q [$];
  int          mbusy = 0;
  int          cyc   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
  endtask

  function automatic longint unsigned p10(input int n);
    longint unsigned r = 1;
    repeat (n) r = r * 10;
    return r;
  endfunction

  // Expected pattern for display digit i of value v (low 8 decimal digits).
  function automatic logic [7:0] exp_seg(input logic [31:0] v, input int i);
    longint unsigned m;
    longint unsigned d;
    m = {32'd0, v} % 64'd100000000;
    if (BLANK_LZ && i > 0 && m < p10(i)) return 8'hFF;
    d = (m / p10(i)) % 10;
    return SEG_TBL[d];
  endfunction

  // Reference model: one value accepted when idle, then 33 busy cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy = 0;
      cyc   = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (mbusy == 0) begin
        if (bus.in_valid) begin
          exp_q.push_back(bus.in_data);
          mbusy = 33;
        end
      end else begin
        mbusy--;
      end
    end
  end

  int          slot      = 0;
  int          gap       = 0;
  logic        prev_busy = 1'b0;
  logic [7:0]  prev_an   = 8'hFE;
  logic [31:0] cur_v     = 32'd0;
  logic [7:0]  an_exp;

  // Monitor: checks handshake status, every scan slot, and pops on commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_an_n", an_n, 8'hFE);
      chk("rst_seg_n", seg_n, 8'hC0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      slot = 0; gap = 0; prev_busy = 1'b0; prev_an = 8'hFE; cur_v = 32'd0;
    end else begin
      gap++;
      chk("in_ready", bus.in_ready, (mbusy == 0));
      chk("busy", busy, (mbusy != 0));
      if (an_n != prev_an) begin
        slot = (slot + 1) % 8;
        an_exp = 8'd1 << slot;
        an_exp = ~an_exp;
        chk("scan_gap", gap, SCAN_DIV);
        chk("an_n", an_n, an_exp);
        chk("seg_n", seg_n, exp_seg(cur_v, slot));
        gap = 0;
        prev_an = an_n;
      end else if (gap > SCAN_DIV) begin
        chk("scan_stall", gap, SCAN_DIV);
        gap = 0;
      end
      if (prev_busy && !busy) begin
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) cur_v = exp_q.pop_front();
      end
      chk("ovf", ovf, (cur_v >= 32'd100000000));
      prev_busy = busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v);
    while (mbusy != 0) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic pulse_during_conv(input logic [31:0] v);
    if (mbusy > 2) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_value();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 9999);
      2: case ($urandom_range(0, 4))
           0: v = 32'd99999999;
           1: v = 32'd100000000;
           2: v = 32'd0;
           3: v = 32'd10;
           default: v = 32'hFFFFFFFF;
         endcase
      default: v = $urandom_range(0, 99999999);
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    send(32'd12345678);  idle(70);
    send(32'd1234);      idle(70);
    send(32'hFFFFFFFF);  idle(70);
    send(32'd0);         idle(70);

    send(32'd87654321);  idle(5);
    pulse_during_conv(32'd11111111);
    idle(70);

    send(32'd55555555);  idle(10);
    do_reset(2);
    idle(40);

    // Time an accept so its commit lands on a scan-tick edge.
    send(32'd13572468);
    while (!(mbusy == 0 && ((cyc + 34) % SCAN_DIV) == 0)) @(negedge clk);
    send(32'd24681357);
    idle(70);

    for (int n = 0; n < 40; n++) begin
      send(pick_value());
      if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, 20));
        pulse_during_conv($urandom);
      end
      idle($urandom_range(0, 40));
    end

    idle(80);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
